seq_core: RTL and testbench

//  Parametrised accumulator sequencer: fetches instruction words from sync ROM,

---
 rtl/seq_core.sv | 236 +++++++++++++++++++++++
 tb/tb_seq_core.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_core.sv
// seq_core: accumulator sequencer with an instruction ROM and a data RAM.
// Each instruction is fetched from a synchronous ROM and decoded one cycle later.
// Operand words are read from the next ROM address.
// Data RAM accesses use a registered address/data/write-enable.
// The debug taps are copies of the architectural registers, one cycle late.
module seq_core #(
   parameter int          DATA_W   = 16,
   parameter int          ADDR_W   = 16,
   parameter int unsigned RESET_PC = 0,
   parameter int          CNT_W    = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              run,
   output logic [ADDR_W-1:0] address_rom,
   input  logic [DATA_W-1:0] q_rom,
   output logic [ADDR_W-1:0] address_ram,
   input  logic [DATA_W-1:0] q_ram,
   output logic [DATA_W-1:0] data_ram,
   output logic              we_ram,
   output logic              halted,
   output logic              illegal,
   output logic [CNT_W-1:0]  retired,
   output logic [ADDR_W-1:0] dbg_pc,
   output logic [DATA_W-1:0] dbg_opcode,
   output logic [DATA_W-1:0] dbg_acc,
   output logic [3:0]        dbg_state
);

   typedef enum logic [3:0] {
      ST_FETCH   = 4'd1,
      ST_DECODE  = 4'd2,
      ST_OPERAND = 4'd3,
      ST_MEM     = 4'd4,
      ST_MEM_RD  = 4'd5,
      ST_HALT    = 4'd6
   } state_t;

   // Opcodes occupy the whole instruction word; anything else is undefined.
   localparam logic [DATA_W-1:0] OP_NOP  = DATA_W'(8'h18);
   localparam logic [DATA_W-1:0] OP_LDI  = DATA_W'(8'h01);
   localparam logic [DATA_W-1:0] OP_LD   = DATA_W'(8'h02);
   localparam logic [DATA_W-1:0] OP_ST   = DATA_W'(8'h03);
   localparam logic [DATA_W-1:0] OP_ADD  = DATA_W'(8'h04);
   localparam logic [DATA_W-1:0] OP_JMP  = DATA_W'(8'h05);
   localparam logic [DATA_W-1:0] OP_JZ   = DATA_W'(8'h06);
   localparam logic [DATA_W-1:0] OP_HALT = DATA_W'(8'h3F);

   localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

   state_t              state_reg,    state_next;
   logic [ADDR_W-1:0]   pc_reg,       pc_next;
   logic [DATA_W-1:0]   acc_reg,      acc_next;
   logic [DATA_W-1:0]   opcode_reg,   opcode_next;
   logic [DATA_W-1:0]   operand_reg,  operand_next;
   logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
   logic [DATA_W-1:0]   ram_data_reg, ram_data_next;
   logic                we_reg,       we_next;
   logic                illegal_reg,  illegal_next;
   logic [CNT_W-1:0]    retired_reg,  retired_next;
   logic                retire;

   logic [ADDR_W-1:0]   dbg_pc_reg;
   logic [DATA_W-1:0]   dbg_opcode_reg;
   logic [DATA_W-1:0]   dbg_acc_reg;
   logic [3:0]          dbg_state_reg;

   // Next-state and datapath decisions for the current state.
   always_comb begin
      state_next    = state_reg;
      pc_next       = pc_reg;
      acc_next      = acc_reg;
      opcode_next   = opcode_reg;
      operand_next  = operand_reg;
      ram_addr_next = ram_addr_reg;
      ram_data_next = ram_data_reg;
      we_next       = 1'b0;
      illegal_next  = illegal_reg;
      retire        = 1'b0;

      case (state_reg)
         ST_FETCH: begin
            // run is only looked at here; an instruction in flight always completes
            if (run) begin
               pc_next    = pc_reg + ADDR_W'(1);
               state_next = ST_DECODE;
            end
         end

         ST_DECODE: begin
            opcode_next = q_rom;
            case (q_rom)
               OP_NOP: begin
                  retire     = 1'b1;
                  state_next = ST_FETCH;
               end
               OP_HALT: begin
                  retire     = 1'b1;
                  state_next = ST_HALT;
               end
               OP_LDI, OP_LD, OP_ST, OP_ADD, OP_JMP, OP_JZ: begin
                  pc_next    = pc_reg + ADDR_W'(1);
                  state_next = ST_OPERAND;
               end
               default: begin
                  // undefined words flag illegal and then behave exactly like NOP
                  illegal_next = 1'b1;
                  retire       = 1'b1;
                  state_next   = ST_FETCH;
               end
            endcase
         end

         ST_OPERAND: begin
            operand_next = q_rom;
            case (opcode_reg)
               OP_LDI: begin
                  acc_next   = q_rom;
                  retire     = 1'b1;
                  state_next = ST_FETCH;
               end
               OP_JMP: begin
                  pc_next    = q_rom[ADDR_W-1:0];
                  retire     = 1'b1;
                  state_next = ST_FETCH;
               end
               OP_JZ: begin
                  if (acc_reg == '0) begin
                     pc_next = q_rom[ADDR_W-1:0];
                  end
                  retire     = 1'b1;
                  state_next = ST_FETCH;
               end
               OP_LD, OP_ADD: begin
                  ram_addr_next = q_rom[ADDR_W-1:0];
                  state_next    = ST_MEM;
               end
               OP_ST: begin
                  ram_addr_next = q_rom[ADDR_W-1:0];
                  ram_data_next = acc_reg;
                  we_next       = 1'b1;
                  state_next    = ST_MEM;
               end
               default: begin
                  state_next = ST_FETCH;
               end
            endcase
         end

         ST_MEM: begin
            // we_ram drops here by default, so the store pulse is exactly one cycle
            if (opcode_reg == OP_ST) begin
               retire     = 1'b1;
               state_next = ST_FETCH;
            end else begin
               state_next = ST_MEM_RD;
            end
         end

         ST_MEM_RD: begin
            if (opcode_reg == OP_LD) begin
               acc_next = q_ram;
            end else begin
               acc_next = acc_reg + q_ram;
            end
            retire     = 1'b1;
            state_next = ST_FETCH;
         end

         ST_HALT: begin
            state_next = ST_HALT;
         end

         default: begin
            state_next = ST_FETCH;
         end
      endcase

      retired_next = retire ? retired_reg + CNT_W'(1) : retired_reg;
   end

   // Architectural registers; reset aborts any instruction in flight, including a pending store.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg    <= ST_FETCH;
         pc_reg       <= PC_INIT;
         acc_reg      <= '0;
         opcode_reg   <= '0;
         operand_reg  <= '0;
         ram_addr_reg <= '0;
         ram_data_reg <= '0;
         we_reg       <= 1'b0;
         illegal_reg  <= 1'b0;
         retired_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         pc_reg       <= pc_next;
         acc_reg      <= acc_next;
         opcode_reg   <= opcode_next;
         operand_reg  <= operand_next;
         ram_addr_reg <= ram_addr_next;
         ram_data_reg <= ram_data_next;
         we_reg       <= we_next;
         illegal_reg  <= illegal_next;
         retired_reg  <= retired_next;
      end
   end

   // Debug taps follow the registers with one cycle of delay, independent of run.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dbg_pc_reg     <= '0;
         dbg_opcode_reg <= '0;
         dbg_acc_reg    <= '0;
         dbg_state_reg  <= '0;
      end else begin
         dbg_pc_reg     <= pc_reg;
         dbg_opcode_reg <= opcode_reg;
         dbg_acc_reg    <= acc_reg;
         dbg_state_reg  <= state_reg;
      end
   end

   assign address_rom = pc_reg;
   assign address_ram = ram_addr_reg;
   assign data_ram    = ram_data_reg;
   assign we_ram      = we_reg;
   assign halted      = (state_reg == ST_HALT);
   assign illegal     = illegal_reg;
   assign retired     = retired_reg;
   assign dbg_pc      = dbg_pc_reg;
   assign dbg_opcode  = dbg_opcode_reg;
   assign dbg_acc     = dbg_acc_reg;
   assign dbg_state   = dbg_state_reg;

endmodule

// File: tb/tb_seq_core.sv
// tb_seq_core: directed programs for seq_core, checked cycle by cycle against an
// instruction-level model plus a few hand-computed end results.
module tb_seq_core;

   localparam int          DW  = 16;
   localparam int          AW  = 16;
   localparam int          CW  = 16;
   localparam int unsigned RPC = 0;

   localparam logic [15:0] NOP = 16'h0018;
   localparam logic [15:0] LDI = 16'h0001;
   localparam logic [15:0] LD  = 16'h0002;
   localparam logic [15:0] ST  = 16'h0003;
   localparam logic [15:0] ADD = 16'h0004;
   localparam logic [15:0] JMP = 16'h0005;
   localparam logic [15:0] JZ  = 16'h0006;
   localparam logic [15:0] HLT = 16'h003F;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          run   = 1'b0;
   logic [AW-1:0] address_rom, address_ram, dbg_pc;
   logic [DW-1:0] q_rom, q_ram, data_ram, dbg_opcode, dbg_acc;
   logic          we_ram, halted, illegal;
   logic [CW-1:0] retired;
   logic [3:0]    dbg_state;

   logic [15:0] rom      [256];
   logic [15:0] ram      [256];
   logic [15:0] ram_init [256];
   logic [15:0] m_ram    [256];
   logic        ram_load = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   int we_cnt = 0;

   seq_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(RPC), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .run(run),
      .address_rom(address_rom), .q_rom(q_rom),
      .address_ram(address_ram), .q_ram(q_ram),
      .data_ram(data_ram), .we_ram(we_ram),
      .halted(halted), .illegal(illegal), .retired(retired),
      .dbg_pc(dbg_pc), .dbg_opcode(dbg_opcode), .dbg_acc(dbg_acc),
      .dbg_state(dbg_state)
   );

   always #5 clock = ~clock;

   // synchronous ROM and RAM, 256 words, low address byte decoded
   always @(posedge clock) begin
      q_rom <= rom[address_rom[7:0]];
      q_ram <= ram[address_ram[7:0]];
      if (ram_load) begin
         for (int i = 0; i < 256; i++) ram[i] <= ram_init[i];
      end else if (we_ram) begin
         ram[address_ram[7:0]] <= data_ram;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- instruction-level model ----------------
   typedef struct {
      logic [3:0]  st;
      logic [15:0] pc;
      logic        we;
      logic [15:0] waddr;
      logic [15:0] wdata;
      logic [15:0] acc;
      logic [15:0] opreg;
      logic [15:0] ret;
      logic        ill;
      logic        halt;
   } cyc_t;

   cyc_t        exp_q[$];
   logic [15:0] a_pc, a_acc, a_opreg, a_ret;
   logic        a_ill, a_halt;

   // expected outputs while waiting at an instruction boundary (or halted)
   function automatic cyc_t idle_rec();
      cyc_t r;
      r.st    = a_halt ? 4'd6 : 4'd1;
      r.pc    = a_pc;
      r.we    = 1'b0;
      r.waddr = 16'h0;
      r.wdata = 16'h0;
      r.acc   = a_acc;
      r.opreg = a_opreg;
      r.ret   = a_ret;
      r.ill   = a_ill;
      r.halt  = a_halt;
      return r;
   endfunction

   // Executes the instruction at a_pc in one step and queues the per-cycle view of
   // the cycles after FETCH (old architectural values until the retiring edge).
   task automatic gen_instr();
      cyc_t        r;
      logic [15:0] op, opnd, pc0, pc1;
      logic        two, undef;
      pc0   = a_pc;
      pc1   = pc0 + 16'd1;
      op    = rom[pc0[7:0]];
      opnd  = rom[pc1[7:0]];
      two   = (op == LDI) || (op == LD) || (op == ST) || (op == ADD) || (op == JMP) || (op == JZ);
      undef = !two && (op != NOP) && (op != HLT);
      r = idle_rec();
      r.st = 4'd2; r.pc = pc1;
      exp_q.push_back(r);
      if (two) begin
         r.st = 4'd3; r.pc = pc0 + 16'd2; r.opreg = op;
         exp_q.push_back(r);
         if (op == ST || op == LD || op == ADD) begin
            r.st = 4'd4; r.waddr = opnd; r.we = (op == ST); r.wdata = a_acc;
            exp_q.push_back(r);
            if (op != ST) begin
               r.st = 4'd5; r.we = 1'b0;
               exp_q.push_back(r);
            end
         end
      end
      a_opreg = op;
      a_ret   = a_ret + 16'd1;
      a_pc    = two ? pc0 + 16'd2 : pc1;
      if (undef) a_ill = 1'b1;
      case (op)
         LDI: a_acc = opnd;
         LD:  a_acc = m_ram[opnd[7:0]];
         ST:  m_ram[opnd[7:0]] = a_acc;
         ADD: a_acc = a_acc + m_ram[opnd[7:0]];
         JMP: a_pc = opnd;
         JZ:  if (a_acc == 16'h0) a_pc = opnd;
         HLT: a_halt = 1'b1;
         default: ;
      endcase
   endtask

   // per-cycle compare against the model, sampled on the falling edge
   initial begin
      cyc_t cur, prv, zr;
      zr  = '{default: '0};
      cur = zr;
      prv = zr;
      forever begin
         @(negedge clock);
         if (reset) begin
            exp_q.delete();
            a_pc = 16'(RPC); a_acc = 16'h0; a_opreg = 16'h0; a_ret = 16'h0;
            a_ill = 1'b0; a_halt = 1'b0;
            we_cnt = 0;
            for (int i = 0; i < 256; i++) m_ram[i] = ram_init[i];
            chk("rst_address_rom", address_rom, RPC);
            chk("rst_we_ram", we_ram, 0);
            chk("rst_halted", halted, 0);
            chk("rst_illegal", illegal, 0);
            chk("rst_retired", retired, 0);
            chk("rst_address_ram", address_ram, 0);
            chk("rst_data_ram", data_ram, 0);
            chk("rst_dbg_pc", dbg_pc, 0);
            chk("rst_dbg_state", dbg_state, 0);
            chk("rst_dbg_acc", dbg_acc, 0);
            chk("rst_dbg_opcode", dbg_opcode, 0);
            cur = idle_rec();
            prv = zr;
         end else begin
            chk("address_rom", address_rom, cur.pc);
            chk("we_ram", we_ram, cur.we);
            if (cur.we) chk("data_ram", data_ram, cur.wdata);
            if (cur.st == 4'd4 || cur.st == 4'd5) chk("address_ram", address_ram, cur.waddr);
            chk("halted", halted, cur.halt);
            chk("illegal", illegal, cur.ill);
            chk("retired", retired, cur.ret);
            chk("dbg_state", dbg_state, prv.st);
            chk("dbg_pc", dbg_pc, prv.pc);
            chk("dbg_acc", dbg_acc, prv.acc);
            chk("dbg_opcode", dbg_opcode, prv.opreg);
            if (we_ram) we_cnt++;
            prv = cur;
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
            end else if (cur.st == 4'd1 && run) begin
               gen_instr();
               cur = exp_q.pop_front();
            end else begin
               cur = idle_rec();
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_cycles(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   // hold reset and clear both memories (ROM to NOP)
   task automatic prep();
      reset    = 1'b1;
      ram_load = 1'b1;
      for (int i = 0; i < 256; i++) begin
         rom[i]      = NOP;
         ram_init[i] = 16'h0;
      end
   endtask

   task automatic go();
      repeat (2) @(posedge clock);
      #2;
      ram_load = 1'b0;
      reset    = 1'b0;
   endtask

   task automatic wait_halt();
      for (int i = 0; i < 60 && !halted; i++) run_cycles(1);
      chk("halt_reached", halted, 1);
      run_cycles(1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rom[i] = NOP; ram[i] = 16'h0; ram_init[i] = 16'h0;
      end

      // LDI 5 ; ST 20h ; HALT
      run = 1'b1;
      prep();
      rom[0] = LDI; rom[1] = 16'h0005; rom[2] = ST; rom[3] = 16'h0020; rom[4] = HLT;
      go();
      run_cycles(8);
      chk("st_not_halted_c8", halted, 0);
      run_cycles(1);
      chk("st_halted_c9", halted, 1);
      chk("st_retired", retired, 3);
      chk("st_ram20", ram[8'h20], 16'h0005);
      chk("st_we_pulses", we_cnt, 1);
      $display("txn ldi_st_halt: ram[20]=%0h retired=%0d we_pulses=%0d", ram[8'h20], retired, we_cnt);

      // LDI FFFF ; ADD 30h ; HALT with RAM[30h]=2
      prep();
      rom[0] = LDI; rom[1] = 16'hFFFF; rom[2] = ADD; rom[3] = 16'h0030; rom[4] = HLT;
      ram_init[8'h30] = 16'h0002;
      go();
      wait_halt();
      chk("add_wrap_acc", dbg_acc, 16'h0001);
      chk("add_retired", retired, 3);
      $display("txn add_wrap: acc=%0h retired=%0d", dbg_acc, retired);

      // LDI 0 ; JZ 7 taken
      prep();
      rom[0] = LDI; rom[1] = 16'h0000; rom[2] = JZ; rom[3] = 16'h0007;
      rom[4] = LDI; rom[5] = 16'h0055; rom[6] = HLT; rom[7] = HLT;
      go();
      wait_halt();
      chk("jz_taken_pc", address_rom, 16'h0008);
      chk("jz_taken_acc", dbg_acc, 16'h0000);
      $display("txn jz_taken: pc=%0h acc=%0h", address_rom, dbg_acc);

      // LDI 1 ; JZ 7 falls through
      prep();
      rom[0] = LDI; rom[1] = 16'h0001; rom[2] = JZ; rom[3] = 16'h0007;
      rom[4] = LDI; rom[5] = 16'h0055; rom[6] = HLT; rom[7] = HLT;
      go();
      wait_halt();
      chk("jz_fall_pc", address_rom, 16'h0007);
      chk("jz_fall_acc", dbg_acc, 16'h0055);
      $display("txn jz_fall: pc=%0h acc=%0h", address_rom, dbg_acc);

      // run held low for 10 cycles, then released
      run = 1'b0;
      prep();
      rom[0] = LDI; rom[1] = 16'h0005; rom[2] = ST; rom[3] = 16'h0020; rom[4] = HLT;
      go();
      run_cycles(10);
      chk("stall_pc", address_rom, RPC);
      chk("stall_dbg_state", dbg_state, 1);
      chk("stall_retired", retired, 0);
      run = 1'b1;
      wait_halt();
      chk("stall_then_ram20", ram[8'h20], 16'h0005);
      chk("stall_then_retired", retired, 3);
      $display("txn stall_release: ram[20]=%0h retired=%0d", ram[8'h20], retired);

      // undefined opcode 0077h, then HALT
      prep();
      rom[0] = 16'h0077; rom[1] = HLT;
      go();
      run_cycles(2);
      chk("ill_flag", illegal, 1);
      chk("ill_pc", address_rom, 16'h0001);
      chk("ill_retired", retired, 1);
      wait_halt();
      chk("ill_sticky", illegal, 1);
      reset = 1'b1;
      #1;
      chk("ill_cleared_by_reset", illegal, 0);
      @(posedge clock);
      #2;
      reset = 1'b0;
      $display("txn illegal_op: illegal set, cleared by reset");

      // reset asserted while ST is in its MEM cycle
      prep();
      rom[0] = LDI; rom[1] = 16'h0009; rom[2] = ST; rom[3] = 16'h0040; rom[4] = HLT;
      go();
      run_cycles(6);
      chk("abort_we_before", we_ram, 1);
      reset = 1'b1;
      #1;
      chk("abort_we_now", we_ram, 0);
      chk("abort_pc", address_rom, RPC);
      @(posedge clock);
      #2;
      reset = 1'b0;
      run_cycles(1);
      chk("abort_acc", dbg_acc, 16'h0000);
      chk("abort_ram40", ram[8'h40], 16'h0000);
      $display("txn reset_in_mem: we=%0b ram[40]=%0h", we_ram, ram[8'h40]);

      // JMP FFFF, HALT at FFFF: pc wraps to 0
      prep();
      rom[0] = JMP; rom[1] = 16'hFFFF; rom[8'hFF] = HLT;
      go();
      wait_halt();
      chk("wrap_pc", address_rom, 16'h0000);
      $display("txn pc_wrap: pc=%0h", address_rom);

      // LD 30h ; ADD 31h ; ST 32h ; HALT
      prep();
      rom[0] = LD; rom[1] = 16'h0030; rom[2] = ADD; rom[3] = 16'h0031;
      rom[4] = ST; rom[5] = 16'h0032; rom[6] = HLT;
      ram_init[8'h30] = 16'h1234; ram_init[8'h31] = 16'h1111;
      go();
      wait_halt();
      chk("ld_add_st_ram32", ram[8'h32], 16'h2345);
      chk("ld_add_st_retired", retired, 4);
      $display("txn ld_add_st: ram[32]=%0h retired=%0d", ram[8'h32], retired);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
